// File: rtl/flappy_pkg.sv
// Shared Flappy Bird constants: screen geometry, bird position, game FSM encoding.
// Pure definitions; no timing.
// Imported by every game block so geometry stays consistent across them.
package flappy_pkg;

   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;
   localparam int PIPE_W   = 52;
   localparam int BIRD_X   = 160;

   // Parked slots sit mid-screen vertically so the renderer never sees a wild value.
   localparam logic [9:0] GAP_RESET = 10'(SCREEN_H / 2);

   // Game FSM encoding, kept as plain constants for older tools.
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_RUN    = 2'd1;
   localparam logic [1:0] ST_FROZEN = 2'd2;

   // Map a 9-bit random value onto 0..range; values above range wrap back down.
   function automatic logic [9:0] fold_gap(input logic [8:0] v, input int range);
      int vi;
      vi = int'(v);
      if (vi > range) begin
         vi = vi - range - 1;
      end
      return 10'(vi);
   endfunction

endpackage

// File: rtl/pipe_scheduler_if.sv
// Pipe scheduler bus: frame/game control in, per-slot pipe state and scoring out.
// Purely wiring; all outputs behind it are registered in the scheduler.
// No backpressure: controls are pulses/levels, outputs are continuously valid.
interface pipe_scheduler_if #(
   parameter int NUM_PIPES = 3
);
   logic                     frame_tick;
   logic                     start;
   logic                     freeze;
   logic [NUM_PIPES*10-1:0]  pipe_x;
   logic [NUM_PIPES*10-1:0]  gap_y;
   logic [NUM_PIPES-1:0]     pipe_active;
   logic                     score_pulse;
   logic [9:0]               score;

   // Game controller / renderer side.
   modport master (
      output frame_tick, start, freeze,
      input  pipe_x, gap_y, pipe_active, score_pulse, score
   );

   // Scheduler side.
   modport slave (
      input  frame_tick, start, freeze,
      output pipe_x, gap_y, pipe_active, score_pulse, score
   );
endinterface

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), free-running random source.
// Advances every clock; q is the registered state.
// No flow control; never reaches zero from a non-zero seed.
module lfsr16 #(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        reset,
   output logic [15:0] q
);

   // Shift left, feeding back the XOR of the tap bits.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q <= SEED;
      end else begin
         q <= {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
      end
   end

endmodule

// File: rtl/pipe_scheduler.sv
// Spawns, scrolls, retires and scores Flappy Bird pipes in a fixed pool of slots.
// Latency: a frame_tick at cycle N is reflected on all outputs at cycle N+1.
// No backpressure: when every slot is busy the spawn is deferred and retried each tick.
module pipe_scheduler
   import flappy_pkg::*;
#(
   parameter int NUM_PIPES  = 3,
   parameter int SCREEN_W   = flappy_pkg::SCREEN_W,
   parameter int PIPE_W     = flappy_pkg::PIPE_W,
   parameter int SPEED      = 2,
   parameter int SPAWN_DIST = 220,
   parameter int GAP_MIN    = 80,
   parameter int GAP_RANGE  = 320,
   parameter int BIRD_X     = flappy_pkg::BIRD_X
) (
   input  logic            clk,
   input  logic            reset,
   pipe_scheduler_if.slave bus
);

   localparam int         CNT_W   = $clog2(SPAWN_DIST + SPEED + 1);
   localparam logic [9:0] X_SPAWN = 10'(SCREEN_W - 1);

   logic [1:0]           state_q;
   logic [CNT_W-1:0]     spawn_cnt;
   logic [CNT_W-1:0]     cnt_inc;
   logic                 spawn_due;
   logic                 tick_en;
   logic [9:0]           score_q;
   logic                 pulse_q;
   logic [15:0]          lfsr_q;
   logic [6:0]           lfsr_unused;
   logic [9:0]           gap_new;
   logic [NUM_PIPES-1:0] act_vec;
   logic [NUM_PIPES-1:0] spawn_oh;
   logic                 any_free;
   logic [NUM_PIPES-1:0] scored_w;
   logic [10:0]          n_scored;
   logic [10:0]          score_sum;
   logic [9:0]           score_next;

   lfsr16 #(.SEED(16'hACE1)) u_lfsr (
      .clk   (clk),
      .reset (reset),
      .q     (lfsr_q)
   );

   // Only the low 9 bits feed the gap; the rest are kept for other consumers of the generator.
   assign lfsr_unused = lfsr_q[15:9];
   assign gap_new     = 10'(GAP_MIN) + fold_gap(lfsr_q[8:0], GAP_RANGE);

   // start always wins, so a tick arriving with it is dropped rather than half-applied.
   assign tick_en   = (state_q == ST_RUN) && bus.frame_tick && !bus.start;
   assign cnt_inc   = spawn_cnt + CNT_W'(SPEED);
   assign spawn_due = cnt_inc >= CNT_W'(SPAWN_DIST);

   // Lowest-index free slot, judged on pre-tick occupancy (isolate lowest zero bit).
   assign spawn_oh = ~act_vec & (act_vec + NUM_PIPES'(1));
   assign any_free = |spawn_oh;

   for (genvar i = 0; i < NUM_PIPES; i++) begin : g_slot
      logic [9:0]  x_r;
      logic [9:0]  g_r;
      logic        act_r;
      logic        retire;
      logic [9:0]  moved_x;
      logic [10:0] old_edge;
      logic [10:0] new_edge;

      assign retire   = act_r && (x_r < 10'(SPEED));
      assign moved_x  = x_r - 10'(SPEED);
      assign old_edge = 11'(x_r) + 11'(PIPE_W);
      assign new_edge = 11'(moved_x) + 11'(PIPE_W);
      // The trailing edge crosses the bird line exactly once per pipe.
      assign scored_w[i] = act_r && !retire && (old_edge >= 11'(BIRD_X)) && (new_edge < 11'(BIRD_X));

      // Slot state: scroll/retire a live pipe, or take a new one when picked for spawn.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            x_r   <= X_SPAWN;
            g_r   <= GAP_RESET;
            act_r <= 1'b0;
         end else if (bus.start) begin
            x_r   <= X_SPAWN;
            g_r   <= GAP_RESET;
            act_r <= 1'b0;
         end else if (tick_en) begin
            if (act_r) begin
               if (retire) begin
                  act_r <= 1'b0;
                  x_r   <= X_SPAWN;
               end else begin
                  x_r <= moved_x;
               end
            end else if (spawn_oh[i] && spawn_due) begin
               act_r <= 1'b1;
               x_r   <= X_SPAWN;
               g_r   <= gap_new;
            end
         end
      end

      assign act_vec[i]            = act_r;
      assign bus.pipe_x[10*i +: 10] = x_r;
      assign bus.gap_y[10*i +: 10]  = g_r;
   end

   // Count scoring slots this tick and saturate the running score.
   always_comb begin
      n_scored = '0;
      for (int i = 0; i < NUM_PIPES; i++) begin
         n_scored = n_scored + 11'(scored_w[i]);
      end
      score_sum  = 11'(score_q) + n_scored;
      score_next = (score_sum > 11'd1023) ? 10'd1023 : score_sum[9:0];
   end

   // Game FSM, spawn distance counter and score.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         spawn_cnt <= CNT_W'(SPAWN_DIST);
         score_q   <= '0;
         pulse_q   <= 1'b0;
      end else begin
         pulse_q <= 1'b0;
         if (bus.start) begin
            state_q   <= ST_RUN;
            spawn_cnt <= CNT_W'(SPAWN_DIST);
            score_q   <= '0;
         end else begin
            case (state_q)
               ST_RUN: begin
                  if (tick_en) begin
                     score_q <= score_next;
                     pulse_q <= |scored_w;
                     if (spawn_due) begin
                        spawn_cnt <= any_free ? '0 : CNT_W'(SPAWN_DIST);
                     end else begin
                        spawn_cnt <= cnt_inc;
                     end
                  end
                  if (bus.freeze) begin
                     state_q <= ST_FROZEN;
                  end
               end
               ST_FROZEN: begin
                  if (!bus.freeze) begin
                     state_q <= ST_RUN;
                  end
               end
               ST_IDLE: begin
                  state_q <= ST_IDLE;
               end
               default: begin
                  state_q <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign bus.pipe_active = act_vec;
   assign bus.score       = score_q;
   assign bus.score_pulse = pulse_q;

endmodule
